// File: rtl/fp_sqrt.sv
// fp_sqrt: IEEE-754 binary32 square root with round-to-nearest-even.
// Restoring digit-by-digit root, one result bit per cycle. It is a stb/ack responder and
// holds only one operation in flight.
// Build option FP_SQRT_DENORM_EN: define it to normalise subnormal operands before the root.
// Left undefined, subnormal operands are flushed to a signed zero.
module fp_sqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [31:0] QNan     = 32'h7FC0_0000;
  localparam logic [31:0] PosInf   = 32'h7F80_0000;
  localparam logic [4:0]  LastIter = 5'd25;

  typedef enum logic [2:0] {
    StGetA,
    StUnpack,
    StClassify,
`ifdef FP_SQRT_DENORM_EN
    StNormalise,
`endif
    StRoot,
    StRound,
    StPutZ
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic               r_ack;
  logic               r_stb;
  logic               w_ack_d;
  logic               w_stb_d;

  logic [31:0]        r_a;
  logic               r_s;
  logic [7:0]         r_exp;
  logic [23:0]        r_man;
  logic signed [9:0]  r_e;
  logic [51:0]        r_rad;
  logic [27:0]        r_rem;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  logic [9:0]         r_er;
  logic [31:0]        r_z;

  logic               w_take;
  logic               w_frac_nz;
  logic               w_exp_max;
  logic               w_exp_zero;
  logic               w_is_nan;
  logic               w_is_zero;
  logic               w_is_sub;
  logic               w_special;
  logic [31:0]        w_special_z;

  logic [23:0]        w_root_m;
  logic signed [9:0]  w_root_e;
  logic [51:0]        w_rad_init;
  logic signed [9:0]  w_er_init;

  logic [1:0]         w_bits;
  logic [29:0]        w_rem_sh;
  logic [30:0]        w_trial;
  logic               w_fits;

  logic [23:0]        w_mant;
  logic               w_guard;
  logic               w_sticky;
  logic               w_inc;
  logic [24:0]        w_mant_sum;
  logic               w_carry;
  logic [9:0]         w_er_fin;
  logic [31:0]        w_round_z;
  logic               w_unused_bits;

  assign w_take = input_a_stb && r_ack && (r_state == StGetA);

  // Operand classification from the unpacked fields.
  assign w_frac_nz  = |r_man[22:0];
  assign w_exp_max  = &r_exp;
  assign w_exp_zero = ~|r_exp;
  assign w_is_nan   = w_exp_max & w_frac_nz;
  assign w_is_zero  = w_exp_zero & ~w_frac_nz;
  assign w_is_sub   = w_exp_zero & w_frac_nz;

  // Special-case result selection; first matching rule wins.
  always_comb begin
    w_special   = 1'b1;
    w_special_z = QNan;
    if (w_is_nan) begin
      w_special_z = QNan;
    end else if (w_is_zero) begin
      w_special_z = r_a;
    end else if (w_is_sub) begin
`ifdef FP_SQRT_DENORM_EN
      w_special   = 1'b0;
`else
      w_special_z = {r_s, 31'b0};
`endif
    end else if (r_s) begin
      w_special_z = QNan;
    end else if (w_exp_max) begin
      w_special_z = PosInf;
    end else begin
      w_special   = 1'b0;
    end
  end

  // Root setup operands: the final normalise cycle feeds its shifted values straight in.
`ifdef FP_SQRT_DENORM_EN
  assign w_root_m = (r_state == StNormalise) ? {r_man[22:0], 1'b0} : r_man;
  assign w_root_e = (r_state == StNormalise) ? r_e - 10'sd1 : r_e;
`else
  assign w_root_m = r_man;
  assign w_root_e = r_e;
`endif

  // Odd exponents fold one factor of two into the radicand so the exponent halves exactly.
  assign w_rad_init = w_root_e[0] ? {w_root_m, 28'b0} : {1'b0, w_root_m, 27'b0};
  assign w_er_init  = (w_root_e >>> 1) + 10'sd127;

  // One restoring root step: trial-subtract (rem<<2 | bits) - (q<<2 | 1).
  assign w_bits   = r_rad[51:50];
  assign w_rem_sh = {r_rem, w_bits};
  assign w_trial  = {1'b0, w_rem_sh} - {3'b000, r_q, 2'b01};
  assign w_fits   = ~w_trial[30];

  // Rounding: q carries two bits below the mantissa (guard, then a sticky contributor).
  assign w_mant     = r_q[25:2];
  assign w_guard    = r_q[1];
  assign w_sticky   = r_q[0] | (|r_rem);
  assign w_inc      = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_sum = {1'b0, w_mant} + {24'b0, w_inc};
  assign w_carry    = w_mant_sum[24];
  assign w_er_fin   = r_er + {9'b0, w_carry};
  assign w_round_z  = {1'b0, w_er_fin[7:0], w_carry ? 23'h0 : w_mant_sum[22:0]};

  // Remainder and exponent headroom bits are provably zero and never read.
  assign w_unused_bits = ^{w_trial[29:28], w_rem_sh[29:28], w_er_fin[9:8], w_mant_sum[23]};

  // State register plus registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StGetA;
      r_ack   <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack_d;
      r_stb   <= w_stb_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StGetA:     if (w_take) w_state_next = StUnpack;
      StUnpack:   w_state_next = StClassify;
      StClassify: begin
        if (w_special) begin
          w_state_next = StPutZ;
`ifdef FP_SQRT_DENORM_EN
        end else if (w_is_sub) begin
          w_state_next = StNormalise;
`endif
        end else begin
          w_state_next = StRoot;
        end
      end
`ifdef FP_SQRT_DENORM_EN
      StNormalise: if (r_man[22]) w_state_next = r_s ? StPutZ : StRoot;
`endif
      StRoot:     if (r_cnt == 5'd0) w_state_next = StRound;
      StRound:    w_state_next = StPutZ;
      StPutZ:     if (output_z_ack) w_state_next = StGetA;
      default:    w_state_next = StGetA;
    endcase
  end

  // Handshake outputs take the value belonging to the state being entered.
  always_comb begin
    w_ack_d = (w_state_next == StGetA);
    w_stb_d = (w_state_next == StPutZ);
  end

  // Datapath: operand capture, unpack, normalise, root iteration and rounding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= 32'b0;
      r_s     <= 1'b0;
      r_exp   <= 8'b0;
      r_man   <= 24'b0;
      r_e     <= 10'sd0;
      r_rad   <= 52'b0;
      r_rem   <= 28'b0;
      r_q     <= 26'b0;
      r_cnt   <= 5'b0;
      r_er    <= 10'b0;
      r_z     <= 32'b0;
    end else begin
      unique case (r_state)
        StGetA: begin
          if (w_take) r_a <= input_a;
        end
        StUnpack: begin
          r_s   <= r_a[31];
          r_exp <= r_a[30:23];
          r_man <= {|r_a[30:23], r_a[22:0]};
          r_e   <= $signed({2'b00, r_a[30:23]}) - 10'sd127;
        end
        StClassify: begin
          if (w_special) begin
            r_z <= w_special_z;
`ifdef FP_SQRT_DENORM_EN
          end else if (w_is_sub) begin
            r_e <= -10'sd126;
`endif
          end else begin
            r_rad <= w_rad_init;
            r_er  <= w_er_init;
            r_rem <= 28'b0;
            r_q   <= 26'b0;
            r_cnt <= LastIter;
          end
        end
`ifdef FP_SQRT_DENORM_EN
        StNormalise: begin
          r_man <= w_root_m;
          r_e   <= w_root_e;
          if (r_man[22]) begin
            if (r_s) begin
              r_z <= QNan;
            end else begin
              r_rad <= w_rad_init;
              r_er  <= w_er_init;
              r_rem <= 28'b0;
              r_q   <= 26'b0;
              r_cnt <= LastIter;
            end
          end
        end
`endif
        StRoot: begin
          r_rad <= r_rad << 2;
          r_q   <= {r_q[24:0], w_fits};
          r_rem <= w_fits ? w_trial[27:0] : w_rem_sh[27:0];
          r_cnt <= r_cnt - 5'd1;
        end
        StRound: begin
          r_z <= w_round_z;
        end
        StPutZ: begin
          r_z <= r_z;
        end
        default: begin
          r_z <= r_z;
        end
      endcase
    end
  end

  assign input_a_ack  = r_ack;
  assign output_z_stb = r_stb;
  assign output_z     = r_z;

endmodule

// File: tb/tb_fp_sqrt.sv
// tb_fp_sqrt: directed plus randomized checks of fp_sqrt against a real-arithmetic model.
// Honours FP_SQRT_DENORM_EN the same way the design does.
module tb_fp_sqrt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = 32'b0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  fp_sqrt dut (
    .clk         (clk),
    .rst         (rst),
    .input_a     (input_a),
    .input_a_stb (input_a_stb),
    .input_a_ack (input_a_ack),
    .output_z    (output_z),
    .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Correctly rounded binary32 sqrt of m * 2^(e-23), m normalised, via double-precision sqrt.
  function automatic logic [31:0] sqrt_ref(input logic [23:0] m, input int e);
    logic [63:0] d;
    logic [63:0] yb;
    real         x;
    real         y;
    int          ye;
    logic [23:0] mant;
    logic        g;
    logic        st;
    logic [24:0] mr;
    d    = {1'b0, 11'(e + 1023), m[22:0], 29'b0};
    x    = $bitstoreal(d);
    y    = $sqrt(x);
    yb   = $realtobits(y);
    ye   = int'(yb[62:52]) - 1023;
    mant = {1'b1, yb[51:29]};
    g    = yb[28];
    st   = |yb[27:0];
    mr   = {1'b0, mant} + ((g && (st || mant[0])) ? 25'd1 : 25'd0);
    if (mr[24]) begin
      mr = 25'h080_0000;
      ye = ye + 1;
    end
    return {1'b0, 8'(ye + 127), mr[22:0]};
  endfunction

  // Expected result and transfer-to-strobe latency for one operand.
  function automatic void model(input logic [31:0] a, output logic [31:0] z, output int lat);
    logic        s;
    logic [7:0]  ex;
    logic [22:0] f;
    s   = a[31];
    ex  = a[30:23];
    f   = a[22:0];
    lat = 2;
    if (ex == 8'hFF && f != 23'd0) begin
      z = QNAN;
    end else if (ex == 8'h00 && f == 23'd0) begin
      z = a;
    end else if (ex == 8'h00) begin
`ifdef FP_SQRT_DENORM_EN
      begin
        int n;
        int p;
        p = 0;
        for (int i = 0; i < 23; i++) if (f[i]) p = i;
        n   = 23 - p;
        lat = 2 + n;
        if (s) begin
          z = QNAN;
        end else begin
          z   = sqrt_ref(24'(f) << n, -126 - n);
          lat = 29 + n;
        end
      end
`else
      z = {s, 31'b0};
`endif
    end else if (s) begin
      z = QNAN;
    end else if (ex == 8'hFF) begin
      z = PINF;
    end else begin
      z   = sqrt_ref({1'b1, f}, int'(ex) - 127);
      lat = 29;
    end
  endfunction

  // One complete transaction; optional back-pressure hold before acknowledging the result.
  task automatic run_op(input logic [31:0] a, input int hold,
                        output logic [31:0] z_obs, output int lat_obs);
    logic [31:0] z_exp;
    int          lat_exp;
    int          w;
    model(a, z_exp, lat_exp);
    w = 0;
    while (!input_a_ack && w < 10) begin
      tick();
      w++;
    end
    chk_bit($sformatf("ack ready a=%h", a), input_a_ack, 1'b1);
    input_a     = a;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    input_a     = $urandom;
    chk_bit($sformatf("ack drop a=%h", a), input_a_ack, 1'b0);
    lat_obs = 0;
    while (!output_z_stb && lat_obs < 200) begin
      tick();
      lat_obs++;
    end
    z_obs = output_z;
    chk_word($sformatf("result a=%h", a), output_z, z_exp);
    chk_int($sformatf("latency a=%h", a), lat_obs, lat_exp);
    for (int i = 0; i < hold; i++) begin
      input_a_stb = 1'b1;
      input_a     = $urandom;
      tick();
      chk_bit("bp stb held", output_z_stb, 1'b1);
      chk_word("bp z stable", output_z, z_exp);
      chk_bit("bp ack low", input_a_ack, 1'b0);
    end
    input_a_stb  = 1'b0;
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk_bit($sformatf("stb drop a=%h", a), output_z_stb, 1'b0);
    chk_bit($sformatf("ack rise a=%h", a), input_a_ack, 1'b1);
  endtask

  initial begin
    logic [31:0] z;
    int          lat;
    logic [31:0] a;
    logic        stale;

    // Reset values.
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk_bit("reset ack", input_a_ack, 1'b0);
    chk_bit("reset stb", output_z_stb, 1'b0);
    chk_word("reset z", output_z, 32'h0);
    rst = 1'b0;
    tick();
    chk_bit("ack after reset", input_a_ack, 1'b1);

    // Directed values with literal expectations.
    run_op(32'h4080_0000, 0, z, lat);
    chk_word("sqrt 4.0", z, 32'h4000_0000);
    chk_int("sqrt 4.0 latency", lat, 29);
    run_op(32'h4110_0000, 0, z, lat);
    chk_word("sqrt 9.0", z, 32'h4040_0000);
    run_op(32'h4000_0000, 0, z, lat);
    chk_word("sqrt 2.0", z, 32'h3FB5_04F3);
    run_op(32'h3F80_0000, 0, z, lat);
    chk_word("sqrt 1.0", z, 32'h3F80_0000);

    // Specials.
    run_op(32'hC080_0000, 0, z, lat);
    chk_word("sqrt -4", z, 32'h7FC0_0000);
    chk_int("sqrt -4 latency", lat, 2);
    run_op(32'h7FC1_2345, 0, z, lat);
    chk_word("sqrt nan", z, 32'h7FC0_0000);
    run_op(32'h8000_0000, 0, z, lat);
    chk_word("sqrt -0", z, 32'h8000_0000);
    run_op(32'h7F80_0000, 0, z, lat);
    chk_word("sqrt +inf", z, 32'h7F80_0000);
    chk_int("sqrt +inf latency", lat, 2);

    // Smallest subnormal.
    run_op(32'h0000_0001, 0, z, lat);
`ifdef FP_SQRT_DENORM_EN
    chk_word("sqrt min subnormal", z, 32'h1A35_04F3);
    chk_int("min subnormal latency", lat, 52);
`else
    chk_word("sqrt min subnormal", z, 32'h0000_0000);
    chk_int("min subnormal latency", lat, 2);
`endif

    // Back-pressure, then the next operand immediately after the ack pulse.
    run_op(32'h42C8_0000, 10, z, lat);
    chk_word("sqrt 100 under back-pressure", z, 32'h4120_0000);
    run_op(32'h4180_0000, 0, z, lat);
    chk_word("sqrt 16 after back-pressure", z, 32'h4080_0000);

    // Reset in the middle of the root iteration.
    input_a     = 32'h4110_0000;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    chk_bit("mid-root reset ack", input_a_ack, 1'b0);
    chk_bit("mid-root reset stb", output_z_stb, 1'b0);
    chk_word("mid-root reset z", output_z, 32'h0);
    rst = 1'b0;
    tick();
    chk_bit("ack after mid-root reset", input_a_ack, 1'b1);
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (output_z_stb) stale = 1'b1;
    end
    chk_bit("no stale stb", stale, 1'b0);
    run_op(32'h4110_0000, 0, z, lat);
    chk_word("sqrt 9.0 after reset", z, 32'h4040_0000);
    chk_int("sqrt 9.0 after reset latency", lat, 29);

    // Randomized operands across classes.
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        2:       a = {1'($urandom), 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
        default: a = {1'b0, 8'($urandom_range(1, 254)), 23'h7F_FFFF - 23'($urandom_range(0, 3))};
      endcase
      run_op(a, 0, z, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
